// File: rtl/srt4_div_core.sv
// srt4_div_core: sequential radix-4 SRT fractional divider with on-the-fly quotient conversion
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               request, sampled only while idle
//   dividend, divisor   X and D (fractions X*2^-W, D*2^-W); need D[W-1]=1 and X<D
//   busy                high while an operation is in progress
//   done                one-cycle pulse, results valid
//   err                 operand precondition violated
//   quotient, remainder Q and Rm with X*2^W = Q*D + Rm, 0 <= Rm < D
module srt4_div_core #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder
);
   localparam int N  = W / 2 + 1;
   localparam int RW = W + 5;
   localparam int CW = $clog2(N);
   typedef enum logic [1:0] {IDLE, ITER, CORR, DONE} state_t;
   state_t                state;
   logic [W-1:0]          d;
   logic [CW-1:0]         cnt;
   // Only the low W quotient bits are kept; the top digit's bits are zero whenever x < d.
   logic [W-1:0]          q_reg, qm_reg;
   logic signed [RW-1:0]  r, s, qd, r_next, r_fin;
   logic signed [5:0]     p, m1, m2;
   logic signed [2:0]     q;
   logic [3:0]            b;
   assign busy = state != IDLE;
   always_comb begin
      s  = r <<< 2;
      b  = d[W-1:W-4];
      p  = s[W+4:W-1];
      // Selection thresholds in units of 1/8, valid for the truncated 4w estimate over each divisor interval.
      m2 = b == 4'd8  ? 6'sd6  :
           b == 4'd9  ? 6'sd7  :
           b <= 4'd11 ? 6'sd8  :
           b == 4'd12 ? 6'sd9  :
           b <= 4'd14 ? 6'sd10 : 6'sd11;
      m1 = b[2] ? 6'sd3 : 6'sd2;
      q  = p >= m2  ? 3'sb010 :
           p >= m1  ? 3'sb001 :
           p >= -m1 ? 3'sb000 :
           p >= -m2 ? 3'sb111 : 3'sb110;
      // |q|*d aligned to the remainder fraction: d sits at <<2, 2d at <<3.
      qd     = q[0] ? {3'b0, d, 2'b0} : q[1] ? {2'b0, d, 3'b0} : '0;
      r_next = q[2] ? s + qd : s - qd;
      r_fin  = r[RW-1] ? r + {3'b0, d, 2'b0} : r;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         done      <= 1'b0;
         err       <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         d         <= '0;
         r         <= '0;
         q_reg     <= '0;
         qm_reg    <= '0;
         cnt       <= '0;
      end else begin
         done <= state == DONE;
         case (state)
            IDLE: if (start) begin
               if (!divisor[W-1] || dividend >= divisor) begin
                  err       <= 1'b1;
                  quotient  <= '0;
                  remainder <= '0;
                  state     <= DONE;
               end else begin
                  d      <= divisor;
                  r      <= {5'b0, dividend};
                  q_reg  <= '0;
                  qm_reg <= '0;
                  cnt    <= '0;
                  err    <= 1'b0;
                  state  <= ITER;
               end
            end
            ITER: begin
               r      <= r_next;
               // Appended bits are q mod 4 for Q and (q-1) mod 4 for QM, whichever prefix is taken.
               q_reg  <= {(q[2] ? qm_reg[W-3:0] : q_reg[W-3:0]), q[1:0]};
               qm_reg <= {((q[2] || q == 3'sb000) ? qm_reg[W-3:0] : q_reg[W-3:0]), q[1:0] - 2'd1};
               cnt    <= cnt + 1'b1;
               if (cnt == CW'(N - 1)) state <= CORR;
            end
            CORR: begin
               quotient  <= r[RW-1] ? qm_reg : q_reg;
               remainder <= r_fin[W+1:2];
               r         <= r_fin;
               state     <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
